mem_arb: RTL and testbench
==========================

Name: mem_arb

Overview:
- Arbitrates the CPU's separate instruction-fetch and load/store request channels onto one shared memory port.
- Sits between the cpu core and the single-ported SoC memory or bus bridge.
- Captures single-cycle request pulses, issues one transaction at a time downstream, and routes each response back to its owner.
- Includes round-robin fairness, a response timeout and sticky error flags.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum cycles to wait for mem_respValid after issue; 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned to the owner when a transaction times out.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ifu_reqValid  in  1  fetch request pulse.
- ifu_addr  in  32  fetch address.
- ifu_respValid  out  1  fetch response pulse.
- ifu_rdata  out  32  fetched word.
- lsu_reqValid  in  1  load/store request pulse.
- lsu_addr  in  32  byte address.
- lsu_size  in  2  0=byte, 1=half, 2=word.
- lsu_wen  in  1  1=store.
- lsu_wdata  in  32  store data, already lane-aligned.
- lsu_wmask  in  4  byte-lane write mask.
- lsu_respValid  out  1  load/store response pulse.
- lsu_rdata  out  32  load data.
- mem_reqValid  out  1  downstream request pulse.
- mem_addr  out  32  downstream address.
- mem_size  out  2  downstream size.
- mem_wen  out  1  downstream write enable.
- mem_wdata  out  32  downstream write data.
- mem_wmask  out  4  downstream write mask.
- mem_respValid  in  1  downstream response pulse.
- mem_rdata  in  32  downstream read data.
- err_timeout  out  1  sticky: at least one transaction timed out.
- err_overrun  out  1  sticky: a request pulse arrived while that requester's slot was already pending.

Behaviour:
- Reset, asynchronous active-high: every output is 0, every pending slot is empty, state=IDLE, last_grant=IFU, timeout counter=0, both error flags=0.
- Capture: a requester's reqValid pulse loads its slot registers on that edge and sets the slot's pending bit.
  - IFU slot fixes size=2, wen=0, wmask=4'hF, wdata=0.
- Overrun: a pulse into a slot whose pending bit is already set is dropped, the original request is kept, and err_overrun is set.
- States (enum): IDLE, WAIT_IFU, WAIT_LSU.
- IDLE to issue: IDLE looks at pending bits as registered at the start of the cycle.
  - If only one slot is pending, it is granted.
  - If both are pending, the slot not equal to last_grant wins. Since last_grant resets to IFU, the first tie goes to LSU.
  - On grant, mem_reqValid=1 for exactly one cycle with the registered fields of the winning slot on the mem_* lines. That slot's pending bit is cleared, last_grant is updated, the timeout counter is cleared, and the FSM moves to WAIT_x.
- Issue latency: a pulse at edge N gives mem_reqValid at cycle N+1 at the earliest, when IDLE.
- Field stability: mem_* fields other than mem_reqValid hold their values until the next issue.
- WAIT_x on response: when mem_respValid=1, mem_rdata is registered. In the next cycle x_respValid=1 for one cycle with x_rdata equal to the registered data. The FSM returns to IDLE in that same edge.
- Back-to-back issue: IDLE may issue in the cycle immediately after returning.
- rdata hold: x_rdata holds its value until that owner's next response.
- Timeout: in WAIT_x the counter increments every cycle. When the counter reaches TIMEOUT_CYCLES-1 without a response (TIMEOUT_CYCLES != 0):
  - the response is delivered to x with rdata=ERR_RDATA;
  - err_timeout is set;
  - the FSM returns to IDLE.
- Stray or late responses: mem_respValid in IDLE is ignored with no output pulse. A response arriving in the same cycle as the timeout wins, and delivers real data without setting err_timeout.
- Pipelined requester: a requester may pulse again before its response arrives. The new pulse is captured, because the pending bit was cleared at issue, and is served after the current transaction.
- Simultaneous capture and grant: a pulse and a grant involving the same slot in the same cycle is legal. The grant uses the old contents and the capture reloads the slot.
- Reset mid-transaction: the in-flight transaction is abandoned with no response to its owner, and any subsequent mem_respValid is ignored as IDLE.
- Error flags clear only on reset.

Decomposition:
- Package mem_arb_defines holds:
  - the arb_state enum (IDLE, WAIT_IFU, WAIT_LSU);
  - grant constants GRANT_IFU=1'b0 and GRANT_LSU=1'b1;
  - the IFU fixed-field constants (size 2'b10, wmask 4'hF).
- Sub-module mem_arb_slot: one pending-request register with load, clear and overrun detect. It is instantiated twice, and the IFU instance has its constant fields tied off.

Test Plan:
- Single fetch: ifu_reqValid pulse with addr=0x8000_0000, memory responds 3 cycles after mem_reqValid with 0x0000_0013 -> mem_reqValid one cycle after the pulse with mem_addr=0x8000_0000, mem_wen=0, mem_size=2; ifu_respValid one cycle after mem_respValid with ifu_rdata=0x0000_0013; lsu_respValid stays 0.
- Tie after reset: both requesters pulse in the same cycle, ifu addr 0x100, lsu store addr 0x200, wdata 0x55, wmask 4'h1 -> first issue goes to LSU with mem_wen=1 and mem_wmask=4'h1; after its response, IFU 0x100 issues; a second tie is then won by IFU.
- Queued request: a lsu pulse arrives while WAIT_IFU is in flight -> LSU issues exactly one cycle after ifu_respValid's FSM return to IDLE, with no lost request and err_overrun=0.
- Overrun: two ifu pulses before the first is issued (hold downstream busy in WAIT_LSU) -> only the first address issues and err_overrun=1.
- Timeout: TIMEOUT_CYCLES=8 and memory never responds -> ifu_respValid fires 8 cycles after issue with 0xDEAD_BEEF and err_timeout=1; a late mem_respValid after that produces no pulse.
- Async reset mid-transaction: assert reset in WAIT_LSU -> all outputs go to 0 immediately; the post-reset mem_respValid is ignored; the next ifu request is served normally.

Source files
------------

// File: rtl/mem_arb_defines.sv
// Shared types and constants for the instruction-fetch / load-store memory arbiter.
package mem_arb_defines;

    // Arbiter FSM: idle, or waiting on the downstream response for one owner.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_IFU = 2'd1,
        WAIT_LSU = 2'd2
    } arb_state;

    // Identity of the most recently granted requester.
    localparam logic GRANT_IFU = 1'b0;
    localparam logic GRANT_LSU = 1'b1;

    // Instruction fetches are always full-word reads.
    localparam logic [1:0] IFU_SIZE  = 2'b10;
    localparam logic [3:0] IFU_WMASK = 4'hF;

    // One captured memory request, as it will be presented downstream.
    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_slot.sv
// One pending-request holding register: captures a request pulse, is cleared
// when the arbiter grants it, and flags pulses that arrive while it is full.
module mem_arb_slot
    import mem_arb_defines::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     load,
    input  logic     clear,
    input  mem_req_t req_in,
    output logic     pending,
    output mem_req_t req,
    output logic     overrun
);

    // A grant in the same cycle frees the slot, so a coincident pulse is a
    // legal reload rather than an overrun.
    assign overrun = load && pending && !clear;

    // Capture on a pulse into a free (or just-granted) slot; drop it otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
            req     <= '0;
        end else begin
            if (load && (!pending || clear)) begin
                req     <= req_in;
                pending <= 1'b1;
            end else if (clear) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Arbiter between the CPU fetch and load/store channels and a single shared
// memory port: one transaction in flight, round-robin on ties, response
// timeout with error data, and sticky error flags.
module mem_arb
    import mem_arb_defines::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        ifu_reqValid,
    input  logic [31:0] ifu_addr,
    output logic        ifu_respValid,
    output logic [31:0] ifu_rdata,

    input  logic        lsu_reqValid,
    input  logic [31:0] lsu_addr,
    input  logic [1:0]  lsu_size,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_respValid,
    output logic [31:0] lsu_rdata,

    output logic        mem_reqValid,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_size,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_respValid,
    input  logic [31:0] mem_rdata,

    output logic        err_timeout,
    output logic        err_overrun
);

    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam int CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TCNT_LAST =
        TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    arb_state         state;
    logic             last_grant;
    logic [CNT_W-1:0] tcount;
    mem_req_t         mem_req_q;

    mem_req_t ifu_req_in;
    mem_req_t lsu_req_in;
    mem_req_t ifu_req;
    mem_req_t lsu_req;
    logic     ifu_pending;
    logic     lsu_pending;
    logic     ifu_overrun;
    logic     lsu_overrun;
    logic     grant_ifu;
    logic     grant_lsu;
    logic     timeout_hit;
    logic     timeout_event;

    // Fetches carry only an address; the remaining fields are fixed word reads.
    assign ifu_req_in = '{addr:  ifu_addr,
                          size:  IFU_SIZE,
                          wen:   1'b0,
                          wdata: 32'h0,
                          wmask: IFU_WMASK};

    assign lsu_req_in = '{addr:  lsu_addr,
                          size:  lsu_size,
                          wen:   lsu_wen,
                          wdata: lsu_wdata,
                          wmask: lsu_wmask};

    mem_arb_slot u_slot_ifu (
        .clock   (clock),
        .reset   (reset),
        .load    (ifu_reqValid),
        .clear   (grant_ifu),
        .req_in  (ifu_req_in),
        .pending (ifu_pending),
        .req     (ifu_req),
        .overrun (ifu_overrun)
    );

    mem_arb_slot u_slot_lsu (
        .clock   (clock),
        .reset   (reset),
        .load    (lsu_reqValid),
        .clear   (grant_lsu),
        .req_in  (lsu_req_in),
        .pending (lsu_pending),
        .req     (lsu_req),
        .overrun (lsu_overrun)
    );

    // Grant from registered pending bits only; on a tie the requester that
    // did not win last time goes next.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state == IDLE) begin
            if (lsu_pending && (!ifu_pending || last_grant == GRANT_IFU)) begin
                grant_lsu = 1'b1;
            end else if (ifu_pending) begin
                grant_ifu = 1'b1;
            end
        end
    end

    // A real response always beats the timeout when both land in one cycle.
    assign timeout_hit   = TIMEOUT_EN && (tcount == TCNT_LAST);
    assign timeout_event = (state != IDLE) && !mem_respValid && timeout_hit;

    assign mem_addr  = mem_req_q.addr;
    assign mem_size  = mem_req_q.size;
    assign mem_wen   = mem_req_q.wen;
    assign mem_wdata = mem_req_q.wdata;
    assign mem_wmask = mem_req_q.wmask;

    // Issue/wait FSM with registered request and response outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            last_grant    <= GRANT_IFU;
            tcount        <= '0;
            mem_reqValid  <= 1'b0;
            mem_req_q     <= '0;
            ifu_respValid <= 1'b0;
            ifu_rdata     <= 32'h0;
            lsu_respValid <= 1'b0;
            lsu_rdata     <= 32'h0;
        end else begin
            mem_reqValid  <= 1'b0;
            ifu_respValid <= 1'b0;
            lsu_respValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_lsu) begin
                        mem_reqValid <= 1'b1;
                        mem_req_q    <= lsu_req;
                        last_grant   <= GRANT_LSU;
                        tcount       <= '0;
                        state        <= WAIT_LSU;
                    end else if (grant_ifu) begin
                        mem_reqValid <= 1'b1;
                        mem_req_q    <= ifu_req;
                        last_grant   <= GRANT_IFU;
                        tcount       <= '0;
                        state        <= WAIT_IFU;
                    end
                end
                WAIT_IFU: begin
                    if (mem_respValid) begin
                        ifu_respValid <= 1'b1;
                        ifu_rdata     <= mem_rdata;
                        state         <= IDLE;
                    end else if (timeout_hit) begin
                        ifu_respValid <= 1'b1;
                        ifu_rdata     <= ERR_RDATA;
                        state         <= IDLE;
                    end else begin
                        tcount <= tcount + 1'b1;
                    end
                end
                WAIT_LSU: begin
                    if (mem_respValid) begin
                        lsu_respValid <= 1'b1;
                        lsu_rdata     <= mem_rdata;
                        state         <= IDLE;
                    end else if (timeout_hit) begin
                        lsu_respValid <= 1'b1;
                        lsu_rdata     <= ERR_RDATA;
                        state         <= IDLE;
                    end else begin
                        tcount <= tcount + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            if (timeout_event) begin
                err_timeout <= 1'b1;
            end
            if (ifu_overrun || lsu_overrun) begin
                err_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: directed scenarios queue hand-computed
// expected issues/responses (with the cycle they must appear in), and a
// negedge monitor pops and compares whenever the DUT pulses an output.
module tb_mem_arb;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ifu_reqValid = 1'b0;
    logic [31:0] ifu_addr = '0;
    logic        ifu_respValid;
    logic [31:0] ifu_rdata;
    logic        lsu_reqValid = 1'b0;
    logic [31:0] lsu_addr = '0;
    logic [1:0]  lsu_size = '0;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_wdata = '0;
    logic [3:0]  lsu_wmask = '0;
    logic        lsu_respValid;
    logic [31:0] lsu_rdata;
    logic        mem_reqValid;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_respValid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        err_timeout;
    logic        err_overrun;

    typedef struct {
        int          cyc;
        logic [70:0] val;
    } exp_t;

    exp_t issue_q[$];
    exp_t ifu_q[$];
    exp_t lsu_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mem_arb #(
        .TIMEOUT_CYCLES (8),
        .ERR_RDATA      (32'hDEAD_BEEF)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ifu_reqValid  (ifu_reqValid),
        .ifu_addr      (ifu_addr),
        .ifu_respValid (ifu_respValid),
        .ifu_rdata     (ifu_rdata),
        .lsu_reqValid  (lsu_reqValid),
        .lsu_addr      (lsu_addr),
        .lsu_size      (lsu_size),
        .lsu_wen       (lsu_wen),
        .lsu_wdata     (lsu_wdata),
        .lsu_wmask     (lsu_wmask),
        .lsu_respValid (lsu_respValid),
        .lsu_rdata     (lsu_rdata),
        .mem_reqValid  (mem_reqValid),
        .mem_addr      (mem_addr),
        .mem_size      (mem_size),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_respValid (mem_respValid),
        .mem_rdata     (mem_rdata),
        .err_timeout   (err_timeout),
        .err_overrun   (err_overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [70:0] actual,
                               input logic [70:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    function automatic logic [70:0] req(input logic [31:0] addr, input logic [1:0] size,
                                        input logic wen, input logic [31:0] wdata,
                                        input logic [3:0] wmask);
        return {addr, size, wen, wdata, wmask};
    endfunction

    function automatic exp_t mk(input int c, input logic [70:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        return e;
    endfunction

    // Called just after a rising edge; inputs are sampled on the next edge,
    // then everything returns to idle levels.
    task automatic applyStimulus(input logic iv, input logic [31:0] ia,
                                 input logic lv, input logic [31:0] la,
                                 input logic [1:0] ls, input logic lw,
                                 input logic [31:0] ld, input logic [3:0] lm,
                                 input logic mv, input logic [31:0] md);
        ifu_reqValid  = iv;
        ifu_addr      = ia;
        lsu_reqValid  = lv;
        lsu_addr      = la;
        lsu_size      = ls;
        lsu_wen       = lw;
        lsu_wdata     = ld;
        lsu_wmask     = lm;
        mem_respValid = mv;
        mem_rdata     = md;
        @(posedge clock);
        #1;
        ifu_reqValid  = 1'b0;
        lsu_reqValid  = 1'b0;
        mem_respValid = 1'b0;
    endtask

    task automatic pulseIfu(input logic [31:0] a);
        applyStimulus(1, a, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pulseLsu(input logic [31:0] a, input logic [1:0] s, input logic w,
                            input logic [31:0] d, input logic [3:0] m);
        applyStimulus(0, 0, 1, a, s, w, d, m, 0, 0);
    endtask

    task automatic memResp(input logic [31:0] d);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, d);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Monitor: every output pulse must match the oldest expected entry.
    always @(negedge clock) begin
        exp_t e;
        if (mem_reqValid) begin
            if (issue_q.size() == 0) begin
                checkOutput("unexpected_issue", {mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask}, '0);
            end else begin
                e = issue_q.pop_front();
                checkOutput("issue_cycle", 71'(cyc), 71'(e.cyc));
                checkOutput("issue_fields", {mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask}, e.val);
            end
        end
        if (ifu_respValid) begin
            if (ifu_q.size() == 0) begin
                checkOutput("unexpected_ifu_resp", 71'(ifu_rdata) | 71'(1) << 70, '0);
            end else begin
                e = ifu_q.pop_front();
                checkOutput("ifu_resp_cycle", 71'(cyc), 71'(e.cyc));
                checkOutput("ifu_rdata", 71'(ifu_rdata), e.val);
            end
        end
        if (lsu_respValid) begin
            if (lsu_q.size() == 0) begin
                checkOutput("unexpected_lsu_resp", 71'(lsu_rdata) | 71'(1) << 70, '0);
            end else begin
                e = lsu_q.pop_front();
                checkOutput("lsu_resp_cycle", 71'(cyc), 71'(e.cyc));
                checkOutput("lsu_rdata", 71'(lsu_rdata), e.val);
            end
        end
    end

    initial begin
        int b;

        // Reset state
        idle(2);
        checkOutput("reset_pulses", {68'h0, mem_reqValid, ifu_respValid, lsu_respValid}, '0);
        checkOutput("reset_mem_fields", {mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask}, '0);
        checkOutput("reset_err_flags", {69'h0, err_timeout, err_overrun}, '0);
        reset = 1'b0;
        idle(1);

        // Single fetch, memory answers three cycles after the issue
        b = cyc;
        issue_q.push_back(mk(b + 2, req(32'h8000_0000, 2'b10, 1'b0, 32'h0, 4'hF)));
        pulseIfu(32'h8000_0000);
        idle(3);
        ifu_q.push_back(mk(b + 5, 71'(32'h0000_0013)));
        memResp(32'h0000_0013);
        idle(2);

        // Tie after reset goes to LSU, then the waiting fetch
        b = cyc;
        issue_q.push_back(mk(b + 2, req(32'h200, 2'b00, 1'b1, 32'h55, 4'h1)));
        issue_q.push_back(mk(b + 4, req(32'h100, 2'b10, 1'b0, 32'h0, 4'hF)));
        applyStimulus(1, 32'h100, 1, 32'h200, 2'b00, 1'b1, 32'h55, 4'h1, 0, 0);
        idle(1);
        lsu_q.push_back(mk(b + 3, 71'(32'h0)));
        memResp(32'h0);
        idle(1);
        ifu_q.push_back(mk(b + 5, 71'(32'hAAAA_0001)));
        memResp(32'hAAAA_0001);

        // Lone load makes LSU the last grant, so the next tie goes to IFU
        b = cyc;
        issue_q.push_back(mk(b + 2, req(32'h204, 2'b01, 1'b0, 32'h0, 4'h0)));
        pulseLsu(32'h204, 2'b01, 1'b0, 32'h0, 4'h0);
        idle(1);
        lsu_q.push_back(mk(b + 3, 71'(32'h0000_BEEF)));
        memResp(32'h0000_BEEF);
        b = cyc;
        issue_q.push_back(mk(b + 2, req(32'h140, 2'b10, 1'b0, 32'h0, 4'hF)));
        issue_q.push_back(mk(b + 4, req(32'h240, 2'b10, 1'b0, 32'h0, 4'hF)));
        applyStimulus(1, 32'h140, 1, 32'h240, 2'b10, 1'b0, 32'h0, 4'hF, 0, 0);
        idle(1);
        ifu_q.push_back(mk(b + 3, 71'(32'h1111_0140)));
        memResp(32'h1111_0140);
        idle(1);
        lsu_q.push_back(mk(b + 5, 71'(32'h2222_0240)));
        memResp(32'h2222_0240);
        idle(2);

        // LSU request queued behind an in-flight fetch
        b = cyc;
        issue_q.push_back(mk(b + 2, req(32'h300, 2'b10, 1'b0, 32'h0, 4'hF)));
        pulseIfu(32'h300);
        idle(1);
        pulseLsu(32'h404, 2'b10, 1'b0, 32'h0, 4'hF);
        idle(1);
        ifu_q.push_back(mk(b + 5, 71'(32'h1111_2222)));
        issue_q.push_back(mk(b + 6, req(32'h404, 2'b10, 1'b0, 32'h0, 4'hF)));
        memResp(32'h1111_2222);
        idle(1);
        lsu_q.push_back(mk(b + 7, 71'(32'h3333_4444)));
        memResp(32'h3333_4444);
        idle(1);
        checkOutput("no_overrun_yet", 71'(err_overrun), 71'(0));

        // Overrun: second fetch pulse while the first is still pending
        b = cyc;
        issue_q.push_back(mk(b + 2, req(32'h500, 2'b01, 1'b0, 32'h0, 4'h0)));
        pulseLsu(32'h500, 2'b01, 1'b0, 32'h0, 4'h0);
        idle(1);
        pulseIfu(32'h600);
        pulseIfu(32'h700);
        lsu_q.push_back(mk(b + 5, 71'(32'h5555_6666)));
        issue_q.push_back(mk(b + 6, req(32'h600, 2'b10, 1'b0, 32'h0, 4'hF)));
        memResp(32'h5555_6666);
        idle(1);
        ifu_q.push_back(mk(b + 7, 71'(32'h7777_8888)));
        memResp(32'h7777_8888);
        idle(3);
        checkOutput("err_overrun_set", 71'(err_overrun), 71'(1));

        // Timeout: no response, error data after 8 cycles, late response ignored
        b = cyc;
        issue_q.push_back(mk(b + 2, req(32'h900, 2'b10, 1'b0, 32'h0, 4'hF)));
        ifu_q.push_back(mk(b + 10, 71'(32'hDEAD_BEEF)));
        pulseIfu(32'h900);
        checkOutput("no_timeout_yet", 71'(err_timeout), 71'(0));
        idle(9);
        memResp(32'h1234_5678);
        idle(2);
        checkOutput("err_timeout_set", 71'(err_timeout), 71'(1));
        checkOutput("ifu_rdata_hold", 71'(ifu_rdata), 71'(32'hDEAD_BEEF));
        checkOutput("lsu_rdata_hold", 71'(lsu_rdata), 71'(32'h5555_6666));

        // Asynchronous reset while a store is in flight
        b = cyc;
        issue_q.push_back(mk(b + 2, req(32'hA00, 2'b10, 1'b1, 32'hCAFE_F00D, 4'hF)));
        pulseLsu(32'hA00, 2'b10, 1'b1, 32'hCAFE_F00D, 4'hF);
        idle(2);
        reset = 1'b1;
        #1;
        checkOutput("async_reset_mem_fields", {mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask}, '0);
        checkOutput("async_reset_rdata", {7'h0, ifu_rdata, lsu_rdata}, '0);
        checkOutput("async_reset_flags", {69'h0, err_timeout, err_overrun}, '0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        memResp(32'hBAD0_BAD0);
        b = cyc;
        issue_q.push_back(mk(b + 2, req(32'hB00, 2'b10, 1'b0, 32'h0, 4'hF)));
        pulseIfu(32'hB00);
        idle(1);
        ifu_q.push_back(mk(b + 3, 71'(32'hC0FF_EE00)));
        memResp(32'hC0FF_EE00);
        idle(3);

        // Nothing expected may be left unobserved
        checkOutput("issue_q_drained", 71'(issue_q.size()), 71'(0));
        checkOutput("ifu_q_drained", 71'(ifu_q.size()), 71'(0));
        checkOutput("lsu_q_drained", 71'(lsu_q.size()), 71'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
